// File: rtl/level_gen.sv
// level_gen: turns single-cycle set/clr request pulses into a level with a minimum dwell
// per level and a one-deep queue for an opposite request. Define LEVEL_GEN_DROP_CNT_EN to add drop_cnt.
module level_gen #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_pulse,
    input  logic       clr_pulse,
    output logic       level_out,
    output logic       busy,
`ifdef LEVEL_GEN_DROP_CNT_EN
    output logic [7:0] drop_cnt,
`endif
    output logic       drop
);

    // state       | meaning
    // S_LOW       | level 0, dwell satisfied
    // S_LOW_HOLD  | level 0, dwell counting
    // S_HIGH      | level 1, dwell satisfied
    // S_HIGH_HOLD | level 1, dwell counting
    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_LOW_HOLD  = 2'd1,
        S_HIGH      = 2'd2,
        S_HIGH_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MIN_LOW_C  = CNT_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pend, pend_n;
    logic             drop_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOW;
            cnt       <= '0;
            pend      <= 1'b0;
            drop      <= 1'b0;
            level_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend      <= pend_n;
            drop      <= drop_n;
            level_out <= (state_n == S_HIGH) || (state_n == S_HIGH_HOLD);
            busy      <= (state_n == S_HIGH_HOLD) || (state_n == S_LOW_HOLD);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        drop_n  = 1'b0;
        if (set_pulse && clr_pulse) begin
            // conflicting requests are discarded; the dwell timer keeps running
            drop_n = 1'b1;
            if ((state == S_HIGH_HOLD && cnt != MIN_HIGH_C) ||
                (state == S_LOW_HOLD  && cnt != MIN_LOW_C))
                cnt_n = cnt + CNT_ONE;
        end else begin
            case (state)
                S_LOW: begin
                    if (set_pulse) begin
                        state_n = S_HIGH_HOLD;
                        cnt_n   = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (clr_pulse) begin
                        state_n = S_LOW_HOLD;
                        cnt_n   = CNT_ONE;
                    end
                end
                S_HIGH_HOLD: begin
                    if (set_pulse && pend) begin
                        pend_n = 1'b0;
                        drop_n = 1'b1;
                    end else if (clr_pulse) begin
                        pend_n = 1'b1;
                    end
                    if (cnt == MIN_HIGH_C) begin
                        if (pend_n) begin
                            state_n = S_LOW_HOLD;
                            cnt_n   = CNT_ONE;
                            pend_n  = 1'b0;
                        end else begin
                            state_n = S_HIGH;
                            cnt_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                S_LOW_HOLD: begin
                    if (clr_pulse && pend) begin
                        pend_n = 1'b0;
                        drop_n = 1'b1;
                    end else if (set_pulse) begin
                        pend_n = 1'b1;
                    end
                    if (cnt == MIN_LOW_C) begin
                        if (pend_n) begin
                            state_n = S_HIGH_HOLD;
                            cnt_n   = CNT_ONE;
                            pend_n  = 1'b0;
                        end else begin
                            state_n = S_LOW;
                            cnt_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                end
            endcase
        end
    end

`ifdef LEVEL_GEN_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= 8'd0;
        else if (drop_n && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule
